// File: rtl/hbridge_gate_driver_if.sv
// Command, status and gate-drive signals between the modulator side and hbridge_gate_driver.
// The driver takes the slave modport; the command source or bench takes the master modport.
interface hbridge_gate_driver_if #(
  parameter int CNT_W = 16
);
  logic             DRV0;
  logic             DRV1;
  logic             stdby;
  logic             fault_n;
  logic             fault_clr;
  logic             A_HI;
  logic             A_LO;
  logic             B_HI;
  logic             B_LO;
  logic             fault_latched;
  logic [CNT_W-1:0] illegal_cnt;

  modport master (
    output DRV0, DRV1, stdby, fault_n, fault_clr,
    input  A_HI, A_LO, B_HI, B_LO, fault_latched, illegal_cnt
  );

  modport slave (
    input  DRV0, DRV1, stdby, fault_n, fault_clr,
    output A_HI, A_LO, B_HI, B_LO, fault_latched, illegal_cnt
  );
endinterface

// File: rtl/hbridge_gate_driver.sv
// H-bridge gate driver: turns DRV0/DRV1 into four gate drives with dead time and a minimum pulse.
// Standby or a latched overcurrent fault forces every gate off.
module hbridge_gate_driver #(
  parameter int DEAD_CYCLES = 4,
  parameter int MIN_PULSE   = 2,
  parameter int CNT_W       = 16
) (
  input logic                 clk,
  input logic                 rst,
  hbridge_gate_driver_if.slave bus
);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_LO      = 3'd1,
    ST_DEAD_UP = 3'd2,
    ST_HI      = 3'd3,
    ST_DEAD_DN = 3'd4
  } leg_state_e;

  localparam logic [7:0] DEAD_C = 8'(DEAD_CYCLES);
  localparam logic [7:0] MIN_C  = 8'(MIN_PULSE);

  logic             fault_meta_r;
  logic             fault_sync_r;
  logic             fault_latched_r;
  logic             fault_latched_s;
  logic             enable_s;
  logic [1:0]       cmd_s;
  logic [1:0]       cmd_prev_r;
  logic             illegal_entry_s;
  logic [CNT_W-1:0] illegal_cnt_r;
  logic [CNT_W-1:0] illegal_cnt_s;
  logic [1:0]       tgt_hi_s;
  leg_state_e       state_r [2];
  leg_state_e       state_s [2];
  logic [7:0]       hold_r  [2];
  logic [7:0]       hold_s  [2];
  logic [7:0]       dead_r  [2];
  logic [7:0]       dead_s  [2];
  logic [1:0]       gate_hi_r;
  logic [1:0]       gate_lo_r;
  logic [1:0]       gate_hi_s;
  logic [1:0]       gate_lo_s;

  // Command decode, fault latch next value, enable and illegal-command counting.
  always_comb begin
    cmd_s    = {bus.DRV1, bus.DRV0};
    // bit 0 is leg A, bit 1 is leg B; 00 and 11 both leave the legs on LO
    tgt_hi_s = {(cmd_s == 2'b10), (cmd_s == 2'b01)};
    // A fault present in the same cycle as a clear keeps the latch set
    if (!fault_sync_r) begin
      fault_latched_s = 1'b1;
    end else if (bus.fault_clr) begin
      fault_latched_s = 1'b0;
    end else begin
      fault_latched_s = fault_latched_r;
    end
    enable_s        = !bus.stdby && !fault_latched_s;
    illegal_entry_s = (cmd_s == 2'b11) && (cmd_prev_r != 2'b11);
    if (illegal_entry_s && (illegal_cnt_r != {CNT_W{1'b1}})) begin
      illegal_cnt_s = illegal_cnt_r + CNT_W'(1);
    end else begin
      illegal_cnt_s = illegal_cnt_r;
    end
  end

  // Per-leg next state; gate enables decode from the next state so they can be registered.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_s[i]   = state_r[i];
      hold_s[i]    = hold_r[i];
      dead_s[i]    = dead_r[i];
      if (!enable_s) begin
        state_s[i] = ST_OFF;
        hold_s[i]  = 8'd0;
        dead_s[i]  = 8'd0;
      end else begin
        case (state_r[i])
          ST_OFF: begin
            state_s[i] = ST_DEAD_DN;
            dead_s[i]  = 8'd1;
          end
          ST_LO: begin
            if (tgt_hi_s[i] && (hold_r[i] >= MIN_C)) begin
              state_s[i] = ST_DEAD_UP;
              dead_s[i]  = 8'd1;
            end else if (hold_r[i] < MIN_C) begin
              hold_s[i] = hold_r[i] + 8'd1;
            end else begin
              hold_s[i] = hold_r[i];
            end
          end
          ST_HI: begin
            if (!tgt_hi_s[i] && (hold_r[i] >= MIN_C)) begin
              state_s[i] = ST_DEAD_DN;
              dead_s[i]  = 8'd1;
            end else if (hold_r[i] < MIN_C) begin
              hold_s[i] = hold_r[i] + 8'd1;
            end else begin
              hold_s[i] = hold_r[i];
            end
          end
          // Dead time always runs to completion regardless of the target
          ST_DEAD_UP: begin
            if (dead_r[i] >= DEAD_C) begin
              state_s[i] = ST_HI;
              hold_s[i]  = 8'd1;
            end else begin
              dead_s[i] = dead_r[i] + 8'd1;
            end
          end
          ST_DEAD_DN: begin
            if (dead_r[i] >= DEAD_C) begin
              state_s[i] = ST_LO;
              hold_s[i]  = 8'd1;
            end else begin
              dead_s[i] = dead_r[i] + 8'd1;
            end
          end
          default: begin
            state_s[i] = ST_OFF;
            hold_s[i]  = 8'd0;
            dead_s[i]  = 8'd0;
          end
        endcase
      end
      gate_hi_s[i] = (state_s[i] == ST_HI);
      gate_lo_s[i] = (state_s[i] == ST_LO);
    end
  end

  // State, fault synchroniser, latch, counter and registered gate outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      // The synchroniser idles at the no-fault level
      fault_meta_r    <= 1'b1;
      fault_sync_r    <= 1'b1;
      fault_latched_r <= 1'b0;
      cmd_prev_r      <= 2'b00;
      illegal_cnt_r   <= {CNT_W{1'b0}};
      gate_hi_r       <= 2'b00;
      gate_lo_r       <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        state_r[i] <= ST_OFF;
        hold_r[i]  <= 8'd0;
        dead_r[i]  <= 8'd0;
      end
    end else begin
      fault_meta_r    <= bus.fault_n;
      fault_sync_r    <= fault_meta_r;
      fault_latched_r <= fault_latched_s;
      cmd_prev_r      <= cmd_s;
      illegal_cnt_r   <= illegal_cnt_s;
      gate_hi_r       <= gate_hi_s;
      gate_lo_r       <= gate_lo_s;
      for (int i = 0; i < 2; i++) begin
        state_r[i] <= state_s[i];
        hold_r[i]  <= hold_s[i];
        dead_r[i]  <= dead_s[i];
      end
    end
  end

  assign bus.A_HI          = gate_hi_r[0];
  assign bus.A_LO          = gate_lo_r[0];
  assign bus.B_HI          = gate_hi_r[1];
  assign bus.B_LO          = gate_lo_r[1];
  assign bus.fault_latched = fault_latched_r;
  assign bus.illegal_cnt   = illegal_cnt_r;

endmodule

// File: tb/tb_hbridge_gate_driver.sv
// Directed bench for hbridge_gate_driver; expectations are queued with a target cycle and
// checked by a negedge monitor. A 2-bit-counter instance exercises counter saturation.
module tb_hbridge_gate_driver;

  typedef struct {
    int          cyc;
    string       tag;
    int          fld;
    logic [15:0] val;
  } exp_t;

  localparam int F_GATES = 0;
  localparam int F_FLT   = 1;
  localparam int F_CNT   = 2;
  localparam int F_CNT2  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_asserts = 0;
  int   n_fails = 0;
  exp_t sb[$];

  hbridge_gate_driver_if #(.CNT_W(16)) bif ();
  hbridge_gate_driver_if #(.CNT_W(2))  sif ();

  assign sif.DRV0      = bif.DRV0;
  assign sif.DRV1      = bif.DRV1;
  assign sif.stdby     = bif.stdby;
  assign sif.fault_n   = bif.fault_n;
  assign sif.fault_clr = bif.fault_clr;

  hbridge_gate_driver #(.DEAD_CYCLES(4), .MIN_PULSE(2), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  hbridge_gate_driver #(.DEAD_CYCLES(4), .MIN_PULSE(2), .CNT_W(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always #8 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // queue an expectation dc cycles after the current edge, kept sorted by cycle
  task automatic push(input int dc, input string tag, input int fld, input logic [15:0] val);
    exp_t e;
    int   i;
    e.cyc = cyc + dc;
    e.tag = tag;
    e.fld = fld;
    e.val = val;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= e.cyc) i++;
    sb.insert(i, e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] obs;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      case (e.fld)
        F_GATES: obs = {12'd0, bif.A_HI, bif.A_LO, bif.B_HI, bif.B_LO};
        F_FLT:   obs = {15'd0, bif.fault_latched};
        F_CNT:   obs = bif.illegal_cnt;
        F_CNT2:  obs = {14'd0, sif.illegal_cnt};
        default: obs = 16'hxxxx;
      endcase
      n_asserts++;
      assert (obs === e.val)
      else begin
        n_fails++;
        $error("FAIL %s @cyc %0d: observed %0h expected %0h", e.tag, cyc, obs, e.val);
      end
    end
  end

  always @(negedge clk) begin
    n_asserts++;
    assert (!(bif.A_HI && bif.A_LO) && !(bif.B_HI && bif.B_LO))
    else begin
      n_fails++;
      $error("FAIL no_shoot_through @cyc %0d: observed %b%b%b%b expected no leg with both gates on",
             cyc, bif.A_HI, bif.A_LO, bif.B_HI, bif.B_LO);
    end
  end

  initial begin
    bif.DRV0 = 1'b0; bif.DRV1 = 1'b0; bif.stdby = 1'b0;
    bif.fault_n = 1'b1; bif.fault_clr = 1'b0;
    rst = 1'b1;
    step(3);

    // reset state, then power-up through dead time to both LO
    rst = 1'b0;
    push(0, "rst_gates", F_GATES, 16'h0);
    push(0, "rst_fault", F_FLT, 16'h0);
    push(0, "rst_cnt", F_CNT, 16'h0);
    push(0, "rst_cnt_sat", F_CNT2, 16'h0);
    for (int k = 1; k <= 4; k++) push(k, "t1_dead", F_GATES, 16'h0);
    push(5, "t1_lo", F_GATES, 16'b0101);
    step(10);

    // leg A LO -> HI
    bif.DRV0 = 1'b1;
    push(1, "t2_alo_fall", F_GATES, 16'b0001);
    push(4, "t2_dead", F_GATES, 16'b0001);
    push(5, "t2_ahi_rise", F_GATES, 16'b1001);
    step(8);
    // 01 -> 10: both legs swap through dead time
    bif.DRV0 = 1'b0; bif.DRV1 = 1'b1;
    push(1, "sw_all_off", F_GATES, 16'b0000);
    push(4, "sw_dead", F_GATES, 16'b0000);
    push(5, "sw_bhi", F_GATES, 16'b0110);
    step(8);
    bif.DRV1 = 1'b0;
    push(1, "b_hi_fall", F_GATES, 16'b0100);
    push(5, "b_lo", F_GATES, 16'b0101);
    step(8);

    // single-cycle pulse stretched to MIN_PULSE
    bif.DRV0 = 1'b1;
    step(1);
    bif.DRV0 = 1'b0;
    push(4, "t3_hi1", F_GATES, 16'b1001);
    push(5, "t3_hi2", F_GATES, 16'b1001);
    push(6, "t3_hi_fall", F_GATES, 16'b0001);
    push(9, "t3_dead", F_GATES, 16'b0001);
    push(10, "t3_lo", F_GATES, 16'b0101);
    step(12);

    // illegal command counting and saturation
    bif.DRV0 = 1'b1; bif.DRV1 = 1'b1;
    push(1, "t4_cnt1", F_CNT, 16'd1);
    push(1, "t4_gates", F_GATES, 16'b0101);
    step(10);
    push(0, "t4_cnt_held", F_CNT, 16'd1);
    push(0, "t4_gates_held", F_GATES, 16'b0101);
    bif.DRV0 = 1'b0; bif.DRV1 = 1'b0;
    step(3);
    bif.DRV0 = 1'b1; bif.DRV1 = 1'b1;
    push(1, "t4_cnt2", F_CNT, 16'd2);
    step(10);
    bif.DRV0 = 1'b0; bif.DRV1 = 1'b0;
    step(2);
    push(0, "t4_cnt2_sat_inst", F_CNT2, 16'd2);
    for (int k = 0; k < 3; k++) begin
      bif.DRV0 = 1'b1; bif.DRV1 = 1'b1;
      step(2);
      bif.DRV0 = 1'b0; bif.DRV1 = 1'b0;
      step(2);
    end
    push(0, "t4_cnt5", F_CNT, 16'd5);
    push(0, "t4_saturated", F_CNT2, 16'd3);

    // fault while A_HI active
    bif.DRV0 = 1'b1;
    step(8);
    push(0, "t5_ahi", F_GATES, 16'b1001);
    bif.fault_n = 1'b0;
    push(3, "t5_off", F_GATES, 16'b0000);
    push(3, "t5_flt", F_FLT, 16'd1);
    step(5);
    bif.fault_clr = 1'b1;
    step(1);
    bif.fault_clr = 1'b0;
    push(0, "t5_clr_ignored", F_FLT, 16'd1);
    step(3);
    bif.fault_n = 1'b1; bif.DRV0 = 1'b0;
    step(4);
    push(0, "t5_still_flt", F_FLT, 16'd1);
    push(0, "t5_still_off", F_GATES, 16'b0000);
    bif.fault_clr = 1'b1;
    step(1);
    bif.fault_clr = 1'b0;
    push(0, "t5_cleared", F_FLT, 16'd0);
    push(0, "t5_off_dead", F_GATES, 16'b0000);
    push(3, "t5_dead", F_GATES, 16'b0000);
    push(4, "t5_lo", F_GATES, 16'b0101);
    step(8);

    // fault and clear in the same cycle: fault wins
    bif.fault_n = 1'b0;
    step(2);
    bif.fault_clr = 1'b1;
    step(1);
    bif.fault_clr = 1'b0;
    push(0, "race_flt", F_FLT, 16'd1);
    push(0, "race_gates", F_GATES, 16'b0000);
    bif.fault_n = 1'b1;
    step(3);
    bif.fault_clr = 1'b1;
    step(1);
    bif.fault_clr = 1'b0;
    step(6);
    push(0, "race_recover", F_GATES, 16'b0101);

    // standby during DEAD_UP
    bif.DRV0 = 1'b1;
    step(2);
    push(0, "t6_deadup", F_GATES, 16'b0001);
    bif.stdby = 1'b1;
    push(1, "t6_stdby_off", F_GATES, 16'b0000);
    step(4);
    bif.stdby = 1'b0; bif.DRV0 = 1'b0;
    push(4, "t6_dead", F_GATES, 16'b0000);
    push(5, "t6_lo", F_GATES, 16'b0101);
    step(8);
    bif.DRV0 = 1'b1;
    push(1, "t6_alo_fall", F_GATES, 16'b0001);
    push(5, "t6_ahi_rise", F_GATES, 16'b1001);
    step(8);

    // reset mid-operation
    rst = 1'b1;
    push(1, "mr_gates", F_GATES, 16'b0000);
    push(1, "mr_flt", F_FLT, 16'd0);
    push(1, "mr_cnt", F_CNT, 16'd0);
    step(1);
    rst = 1'b0; bif.DRV0 = 1'b0;
    push(5, "mr_lo", F_GATES, 16'b0101);
    step(8);

    for (int k = 0; k < 50 && sb.size() > 0; k++) step(1);
    n_asserts++;
    assert (sb.size() == 0)
    else begin
      n_fails++;
      $error("FAIL drain: observed %0d pending expectations, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
